// File: rtl/butterfly_seq_pkg.sv
// Shared types and address arithmetic for the radix-2 DIT butterfly sequencer.
package butterfly_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } seq_state_e;

    // Fields are wide enough for any practical transform; callers slice to size.
    localparam int unsigned FIELD_W = 16;

    typedef struct packed {
        logic [FIELD_W-1:0] addr_a;
        logic [FIELD_W-1:0] addr_b;
        logic [FIELD_W-1:0] tw_idx;
    } bfly_addr_t;

    // In-place DIT addressing for butterfly i of stage s:
    // a = (grp << (s+1)) | k, b = a | half, twiddle = k << (log2n-1-s).
    function automatic bfly_addr_t bfly_addr(input int unsigned s,
                                             input int unsigned i,
                                             input int unsigned log2n);
        int unsigned half;
        int unsigned k;
        int unsigned grp;
        int unsigned a;
        int unsigned b;
        int unsigned tw;
        bfly_addr_t  r;
        half     = 32'd1 << s;
        k        = i & (half - 32'd1);
        grp      = i >> s;
        a        = (grp << (s + 32'd1)) | k;
        b        = a | half;
        tw       = k << (log2n - 32'd1 - s);
        r.addr_a = a[FIELD_W-1:0];
        r.addr_b = b[FIELD_W-1:0];
        r.tw_idx = tw[FIELD_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/butterfly_stage_sequencer_addr_gen.sv
// bfly_addr_gen: combinational wrapper that maps (stage, index) onto
// sample-RAM address pairs and the twiddle-ROM index.
module bfly_addr_gen #(
    parameter int LOG2N = 3,
    parameter int AW    = LOG2N,
    parameter int TW_W  = (LOG2N > 1) ? LOG2N - 1 : 1,
    parameter int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1,
    parameter int IW    = (LOG2N > 1) ? LOG2N - 1 : 1
) (
    input  logic [SW-1:0]   stage_i,
    input  logic [IW-1:0]   idx_i,
    output logic [AW-1:0]   addr_a_o,
    output logic [AW-1:0]   addr_b_o,
    output logic [TW_W-1:0] tw_idx_o
);
    import butterfly_seq_pkg::*;

    bfly_addr_t addr;

    // Evaluate the shared address function and trim to port widths.
    always_comb begin
        addr     = bfly_addr(32'(stage_i), 32'(idx_i), 32'(LOG2N));
        addr_a_o = addr.addr_a[AW-1:0];
        addr_b_o = addr.addr_b[AW-1:0];
        tw_idx_o = addr.tw_idx[TW_W-1:0];
    end

endmodule

// File: rtl/butterfly_stage_sequencer.sv
// butterfly_stage_sequencer: steps one shared butterfly through every stage
// of an in-place radix-2 DIT FFT (READ -> ISSUE -> WAIT per butterfly).
// Optional macro BUTTERFLY_SEQ_PERF_EN adds a 32-bit busy-cycle counter output.
//
// Butterfly handshake: a transfer happens on a rising edge where val and rdy are
// both high; val and its payload (addresses, tw_idx) stay stable until then.
module butterfly_stage_sequencer #(
    parameter int N_SAMPLES = 8,
    parameter int LOG2N     = $clog2(N_SAMPLES),
    parameter int AW        = LOG2N,
    localparam int TW_W     = (LOG2N > 1) ? LOG2N - 1 : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr_a,
    output logic [AW-1:0]   rd_addr_b,
    output logic [TW_W-1:0] tw_idx,
    output logic            bfly_recv_val,
    input  logic            bfly_recv_rdy,
    input  logic            bfly_send_val,
    output logic            bfly_send_rdy,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr_a,
    output logic [AW-1:0]   wr_addr_b
`ifdef BUTTERFLY_SEQ_PERF_EN
    ,
    output logic [31:0]     cycle_count
`endif
);
    import butterfly_seq_pkg::*;

    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int IW = (LOG2N > 1) ? LOG2N - 1 : 1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_SAMPLES / 2 - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2N - 1);

    seq_state_e    state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d;

    logic [AW-1:0]   gen_addr_a;
    logic [AW-1:0]   gen_addr_b;
    logic [TW_W-1:0] gen_tw_idx;

    bfly_addr_gen #(
        .LOG2N (LOG2N),
        .AW    (AW),
        .TW_W  (TW_W),
        .SW    (SW),
        .IW    (IW)
    ) u_addr_gen (
        .stage_i  (stage_q),
        .idx_i    (idx_q),
        .addr_a_o (gen_addr_a),
        .addr_b_o (gen_addr_b),
        .tw_idx_o (gen_tw_idx)
    );

    // State, counters and the registered done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter advance and handshake strobes.
    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        idx_d         = idx_q;
        done_d        = 1'b0;
        rd_en         = 1'b0;
        bfly_recv_val = 1'b0;
        bfly_send_rdy = 1'b0;
        wr_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    stage_d = '0;
                    idx_d   = '0;
                end
            end
            READ: begin
                rd_en   = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                bfly_recv_val = 1'b1;
                if (bfly_recv_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                bfly_send_rdy = 1'b1;
                wr_en         = bfly_send_val;
                if (bfly_send_val) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = READ;
                    end else if (stage_q != STAGE_LAST) begin
                        idx_d   = '0;
                        stage_d = stage_q + SW'(1);
                        state_d = READ;
                    end else begin
                        idx_d   = '0;
                        stage_d = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Addresses are forced to zero while idle so the port is quiet between transforms;
    // the write addresses mirror the read pair because the update is in place.
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign rd_addr_a = busy ? gen_addr_a : '0;
    assign rd_addr_b = busy ? gen_addr_b : '0;
    assign tw_idx    = busy ? gen_tw_idx : '0;
    assign wr_addr_a = rd_addr_a;
    assign wr_addr_b = rd_addr_b;

`ifdef BUTTERFLY_SEQ_PERF_EN
    logic [31:0] cycle_q, cycle_d;

    // Busy-cycle count: cleared on an accepted start, saturating, held while idle.
    always_comb begin
        cycle_d = cycle_q;
        if (state_q == IDLE) begin
            if (start) begin
                cycle_d = '0;
            end
        end else if (cycle_q != 32'hFFFF_FFFF) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_count = cycle_q;
`endif

endmodule

// File: tb/tb_butterfly_stage_sequencer.sv
// Bench for butterfly_stage_sequencer (N_SAMPLES=8): scoreboard of expected
// butterfly address pairs, a behavioural butterfly, directed and random runs.
module tb_butterfly_stage_sequencer;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int AW    = 3;
  localparam int TW_W  = 2;
  localparam int NBF   = (N / 2) * LOG2N;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy, done, rd_en;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [TW_W-1:0] tw_idx;
  logic bfly_recv_val, bfly_recv_rdy, bfly_send_val, bfly_send_rdy, wr_en;
`ifdef BUTTERFLY_SEQ_PERF_EN
  logic [31:0] cycle_count;
`endif

  always #5 clk = ~clk;

  butterfly_stage_sequencer #(.N_SAMPLES(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .rd_en         (rd_en),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .tw_idx        (tw_idx),
    .bfly_recv_val (bfly_recv_val),
    .bfly_recv_rdy (bfly_recv_rdy),
    .bfly_send_val (bfly_send_val),
    .bfly_send_rdy (bfly_send_rdy),
    .wr_en         (wr_en),
    .wr_addr_a     (wr_addr_a),
    .wr_addr_b     (wr_addr_b)
`ifdef BUTTERFLY_SEQ_PERF_EN
    ,
    .cycle_count   (cycle_count)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];   // {addr_a[2:0], addr_b[2:0], tw[1:0]}
  int cyc = 0;
  int writes, rd_count, done_count, last_wr_cyc, first_rd_cyc;
  int rst_gen = 0;
  int send_delay = 1;
  bit rand_rdy = 1'b0;
  logic [31:0] perf_hold;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: for stage s, every sample j whose bit s is clear pairs with
  // j + 2^s, and uses twiddle W_N^((j mod 2^s) * N / 2^(s+1)).
  task automatic push_expected();
    int half, tw;
    for (int s = 0; s < LOG2N; s++) begin
      half = 1 << s;
      for (int j = 0; j < N; j++) begin
        if (((j / half) % 2) == 0) begin
          tw = (j % half) * (N / (2 * half));
          exp_q.push_back({3'(j), 3'(j + half), 2'(tw)});
        end
      end
    end
  endtask

  // ---------------- behavioural butterfly ----------------
  // Accepts on val&rdy, presents its result send_delay cycles later, holds it
  // until the sequencer takes it. A reset abandons the butterfly in flight.
  initial begin
    int g;
    bfly_send_val = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bfly_recv_val && bfly_recv_rdy) begin
        g = rst_gen;
        @(posedge clk);
        for (int d = 1; d < send_delay; d++) @(posedge clk);
        #1;
        if (g == rst_gen) begin
          bfly_send_val = 1'b1;
          for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bfly_send_rdy || g != rst_gen) break;
          end
          @(posedge clk);
          #1 bfly_send_val = 1'b0;
        end
      end
    end
  end

  // Random operand backpressure when enabled.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 bfly_recv_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      if (bfly_recv_val && bfly_recv_rdy) begin
        check("issue_queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("issue_pair_tw", {rd_addr_a, rd_addr_b, tw_idx}, exp_q[0]);
      end
      if (wr_en) begin
        check("write_queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_pair", {wr_addr_a, wr_addr_b}, e[7:2]);
        end
        writes++;
        last_wr_cyc = cyc;
      end
      if (rd_en) begin
        if (rd_count == 0) first_rd_cyc = cyc;
        rd_count++;
      end
      if (bfly_send_rdy && !bfly_send_val) check("no_write_without_result", wr_en, 0);
      if (done) begin
        done_count++;
        check("done_one_after_last_write", cyc, last_wr_cyc + 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch_now();
    push_expected();
    writes = 0; rd_count = 0; done_count = 0; last_wr_cyc = -10; first_rd_cyc = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic launch();
    @(posedge clk);
    #1;
    launch_now();
  endtask

  task automatic wait_writes(input int n);
    bit ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk); #1;
      if (writes >= n) begin ok = 1'b1; break; end
    end
    if (!ok) check("timeout_waiting_writes", writes, n);
  endtask

  // Returns in the done cycle (negedge + 1). exp_len = 0 skips the latency check.
  task automatic wait_finish(input int exp_len);
    bit ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk); #1;
      if (done_count > 0) begin ok = 1'b1; break; end
    end
    check("done_seen", ok, 1);
    check("write_count", writes, NBF);
    check("read_count", rd_count, NBF);
    check("scoreboard_drained", exp_q.size(), 0);
    check("idle_in_done_cycle", busy, 0);
    if (exp_len != 0) check("transform_latency", last_wr_cyc - first_rd_cyc + 1, exp_len);
`ifdef BUTTERFLY_SEQ_PERF_EN
    check("cycle_count_at_done", cycle_count, last_wr_cyc - first_rd_cyc + 1);
    perf_hold = cycle_count;
`endif
  endtask

  task automatic post_idle();
    repeat (3) begin
      @(negedge clk); #1;
    end
    check("single_done_pulse", done_count, 1);
    check("idle_outputs_quiet", {busy, done, rd_en, bfly_recv_val, bfly_send_rdy, wr_en}, 0);
`ifdef BUTTERFLY_SEQ_PERF_EN
    check("cycle_count_holds", cycle_count, perf_hold);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    bfly_recv_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("outputs_in_reset",
          {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, bfly_recv_val,
           bfly_send_rdy, wr_en, wr_addr_a, wr_addr_b}, 0);
`ifdef BUTTERFLY_SEQ_PERF_EN
    check("cycle_count_reset", cycle_count, 0);
`endif
    @(posedge clk); #1 reset = 1'b0;

    // Address sweep with a 1-cycle butterfly: 3 cycles per butterfly.
    send_delay = 1;
    launch();
    wait_finish(3 * NBF);
    // Back-to-back start in the done cycle.
    launch_now();
    @(negedge clk); #1;
    check("b2b_busy", busy, 1);
    check("b2b_first_read", {rd_en, rd_addr_a, rd_addr_b}, {1'b1, 3'd0, 3'd1});
`ifdef BUTTERFLY_SEQ_PERF_EN
    check("b2b_cycle_count_cleared", cycle_count, 0);
`endif
    wait_finish(3 * NBF);
    post_idle();

    // Backpressure on stage 1, butterfly 1.
    launch();
    wait_writes(5);
    bfly_recv_rdy = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bfly_recv_val) break;
      @(negedge clk); #1;
    end
    for (int t = 0; t < 5; t++) begin
      check("stall_recv_val", bfly_recv_val, 1);
      check("stall_addr_tw", {rd_addr_a, rd_addr_b, tw_idx}, {3'd1, 3'd3, 2'd2});
      check("stall_no_read", rd_en, 0);
      if (t < 4) begin @(negedge clk); #1; end
    end
    check("stall_read_count", rd_count, 6);
    @(posedge clk); #1 bfly_recv_rdy = 1'b1;
    wait_finish(0);
    post_idle();

    // Slow butterfly result.
    send_delay = 7;
    launch();
    wait_finish(NBF * (2 + 7));
    post_idle();

    // Start while busy is ignored.
    send_delay = 1;
    launch();
    wait_writes(5);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_finish(3 * NBF);
    post_idle();

    // Reset in WAIT of stage 1.
    send_delay = 7;
    launch();
    for (int t = 0; t < 500; t++) begin
      if (writes >= 4 && bfly_send_rdy) break;
      @(negedge clk); #1;
    end
    check("reached_wait_stage1", {writes, bfly_send_rdy}, {32'd4, 1'b1});
    reset = 1'b1;
    rst_gen++;
    @(negedge clk); #1;
    check("outputs_after_mid_reset",
          {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, bfly_recv_val,
           bfly_send_rdy, wr_en, wr_addr_a, wr_addr_b}, 0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    send_delay = 1;
    launch();
    @(negedge clk); #1;
    check("restart_first_pair", {rd_en, rd_addr_a, rd_addr_b}, {1'b1, 3'd0, 3'd1});
    wait_finish(3 * NBF);
    post_idle();

    // Randomised butterfly latency and operand backpressure.
    for (int r = 0; r < 4; r++) begin
      send_delay = $urandom_range(1, 4);
      rand_rdy = 1'b1;
      repeat ($urandom_range(0, 5)) @(posedge clk);
      launch();
      wait_finish(0);
      rand_rdy = 1'b0;
      @(posedge clk); #1 bfly_recv_rdy = 1'b1;
      post_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
